// File: rtl/expr_seq_pkg.sv
// Shared definitions for the expression-solver control sequencer.
//   - seq_state_e : sequencer state encoding (IDLE, RUN, DONE)
//   - CW_*        : bit offsets and widths of the fields in a control word
//   - cw()        : packs individual fields into a control word
//   - DEFAULT_PROG: the seven-step solver program, step 0 in the LSBs
package expr_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

    localparam int unsigned CW_W     = 10;
    localparam int unsigned CW_STEPS = 7;

    // Control word field layout
    localparam int unsigned CW_LX = 0;  // load X register
    localparam int unsigned CW_LS = 1;  // load S register
    localparam int unsigned CW_LH = 2;  // load H register
    localparam int unsigned CW_H  = 3;  // H input select
    localparam int unsigned CW_M0 = 4;  // mux 0 select, bits 5:4
    localparam int unsigned CW_M1 = 6;  // mux 1 select, bits 7:6
    localparam int unsigned CW_M2 = 8;  // mux 2 select, bits 9:8

    function automatic logic [CW_W-1:0] cw(
        input logic [1:0] m2,
        input logic [1:0] m1,
        input logic [1:0] m0,
        input logic       h,
        input logic       lh,
        input logic       ls,
        input logic       lx
    );
        return {m2, m1, m0, h, lh, ls, lx};
    endfunction

    // Highest step first so that step 0 lands in the LSBs.
    localparam logic [CW_STEPS*CW_W-1:0] DEFAULT_PROG = {
        cw(2'd0, 2'd3, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0),  // step 6
        cw(2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1),  // step 5
        cw(2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0),  // step 4
        cw(2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0),  // step 3
        cw(2'd0, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0),  // step 2
        cw(2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0),  // step 1
        cw(2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1)   // step 0
    };

endpackage

// File: rtl/seq_rom.sv
// Combinational program lookup: returns the control word stored for a step.
//   idx  : step index to look up
//   word : PROGRAM word for idx; zero for indices beyond NUM_STEPS-1
module seq_rom
    import expr_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 7,
    parameter int unsigned CW_WIDTH  = 10,
    parameter int unsigned STEP_W    = 3,
    parameter logic [NUM_STEPS*CW_WIDTH-1:0] PROGRAM = '0
) (
    input  logic [STEP_W-1:0]   idx,
    output logic [CW_WIDTH-1:0] word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (idx == STEP_W'(i)) begin
                word = PROGRAM[i*CW_WIDTH +: CW_WIDTH];
            end
        end
    end

endmodule

// File: rtl/expr_sequencer.sv
// Control sequencer for the expression-solver datapath. Replays PROGRAM one
// step per cycle for n_pass+1 passes, with stall and abort, and pulses done
// for one cycle after the final step.
//   clk, rst  : clock, synchronous active-high reset
//   start     : run request, accepted only in IDLE without abort
//   n_pass    : number of passes minus one, latched on accepted start
//   stall     : freeze current step while in RUN
//   abort     : end the run immediately, no done pulse
//   ctrl      : registered control word to the datapath
//   step_idx  : current step within the pass
//   pass_idx  : current pass
//   busy      : high while in RUN
//   done      : one-cycle completion pulse
module expr_sequencer
    import expr_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 7,
    parameter int unsigned CW_WIDTH  = 10,
    parameter int unsigned PASS_W    = 4,
    parameter logic [NUM_STEPS*CW_WIDTH-1:0] PROGRAM = DEFAULT_PROG,
    localparam int unsigned STEP_W   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PASS_W-1:0]   n_pass,
    input  logic                stall,
    input  logic                abort,
    output logic [CW_WIDTH-1:0] ctrl,
    output logic [STEP_W-1:0]   step_idx,
    output logic [PASS_W-1:0]   pass_idx,
    output logic                busy,
    output logic                done
);

    seq_state_e          state_q;
    logic [CW_WIDTH-1:0] ctrl_q;
    logic [STEP_W-1:0]   step_q;
    logic [PASS_W-1:0]   pass_q;
    logic [PASS_W-1:0]   npass_q;
    logic                busy_q;
    logic                done_q;

    logic                last_step;
    logic [STEP_W-1:0]   next_step;
    logic [STEP_W-1:0]   rom_idx;
    logic [CW_WIDTH-1:0] rom_word;

    assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));
    assign next_step = last_step ? '0 : step_q + 1'b1;
    // In IDLE the word being loaded is step 0, otherwise the step about to run.
    assign rom_idx   = (state_q == StRun) ? next_step : '0;

    seq_rom #(
        .NUM_STEPS (NUM_STEPS),
        .CW_WIDTH  (CW_WIDTH),
        .STEP_W    (STEP_W),
        .PROGRAM   (PROGRAM)
    ) u_rom (
        .idx  (rom_idx),
        .word (rom_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ctrl_q  <= '0;
            step_q  <= '0;
            pass_q  <= '0;
            npass_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q <= StRun;
                        npass_q <= n_pass;
                        ctrl_q  <= rom_word;
                        step_q  <= '0;
                        pass_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                        ctrl_q  <= '0;
                        step_q  <= '0;
                        pass_q  <= '0;
                        busy_q  <= 1'b0;
                    end else if (!stall) begin
                        if (last_step && (pass_q == npass_q)) begin
                            state_q <= StDone;
                            ctrl_q  <= '0;
                            step_q  <= '0;
                            pass_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            ctrl_q <= rom_word;
                            step_q <= next_step;
                            if (last_step) begin
                                pass_q <= pass_q + 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ctrl_q  <= '0;
                    step_q  <= '0;
                    pass_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl     = ctrl_q;
    assign step_idx = step_q;
    assign pass_idx = pass_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_expr_sequencer.sv
// Bench for expr_sequencer: a default instance (7 steps x 10 bits) and a small
// custom instance (3 steps x 4 bits) driven by the same inputs, each compared
// every cycle against a run-position model.
module tb_expr_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stall, abort;
    logic [3:0] n_pass;

    logic [9:0] ctrl_a;
    logic [2:0] step_a;
    logic [3:0] pass_a;
    logic       busy_a, done_a;

    logic [3:0] ctrl_b;
    logic [1:0] step_b;
    logic [3:0] pass_b;
    logic       busy_b, done_b;

    always #5 clk = ~clk;

    expr_sequencer u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_pass   (n_pass),
        .stall    (stall),
        .abort    (abort),
        .ctrl     (ctrl_a),
        .step_idx (step_a),
        .pass_idx (pass_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    expr_sequencer #(
        .NUM_STEPS (3),
        .CW_WIDTH  (4),
        .PASS_W    (4),
        .PROGRAM   (12'hC5A)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_pass   (n_pass),
        .stall    (stall),
        .abort    (abort),
        .ctrl     (ctrl_b),
        .step_idx (step_b),
        .pass_idx (pass_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Program contents written out independently of the package.
    int prog_a[7] = '{'h001, 'h012, 'h084, 'h108, 'h062, 'h305, 'h0F6};
    int prog_b[3] = '{'hA, 'h5, 'hC};
    int nst[2]    = '{7, 3};

    // Model: mode 0 idle, 1 run, 2 done; pos is the linear position in the run.
    int mode[2]  = '{0, 0};
    int pos[2]   = '{0, 0};
    int total[2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic [3:0] np,
                              input logic st, input logic ab);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                mode[i] = 0;
                pos[i]  = 0;
            end else if (mode[i] == 0) begin
                if (s && !ab) begin
                    mode[i]  = 1;
                    pos[i]   = 0;
                    total[i] = (int'(np) + 1) * nst[i];
                end
            end else if (mode[i] == 1) begin
                if (ab) begin
                    mode[i] = 0;
                end else if (!st) begin
                    pos[i]++;
                    if (pos[i] == total[i]) mode[i] = 2;
                end
            end else begin
                mode[i] = 0;
            end
        end
    endtask

    task automatic compare();
        int e_step, e_pass, e_ctrl;
        for (int i = 0; i < 2; i++) begin
            e_step = (mode[i] == 1) ? pos[i] % nst[i] : 0;
            e_pass = (mode[i] == 1) ? pos[i] / nst[i] : 0;
            e_ctrl = (mode[i] != 1) ? 0 : (i == 0) ? prog_a[e_step] : prog_b[e_step];
            if (i == 0) begin
                check("a.ctrl", 32'(ctrl_a), 32'(e_ctrl));
                check("a.step", 32'(step_a), 32'(e_step));
                check("a.pass", 32'(pass_a), 32'(e_pass));
                check("a.busy", 32'(busy_a), 32'(mode[0] == 1));
                check("a.done", 32'(done_a), 32'(mode[0] == 2));
            end else begin
                check("b.ctrl", 32'(ctrl_b), 32'(e_ctrl));
                check("b.step", 32'(step_b), 32'(e_step));
                check("b.pass", 32'(pass_b), 32'(e_pass));
                check("b.busy", 32'(busy_b), 32'(mode[1] == 1));
                check("b.done", 32'(done_b), 32'(mode[1] == 2));
            end
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic [3:0] np,
                         input logic st, input logic ab);
        rst    = r;
        start  = s;
        n_pass = np;
        stall  = st;
        abort  = ab;
        @(posedge clk);
        model_edge(r, s, np, st, ab);
        #1;
        compare();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stall  = 1'b0;
        abort  = 1'b0;
        n_pass = 4'd0;

        // Reset state
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);

        // Single pass
        cycle(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        idle(10);

        // Three passes
        cycle(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        idle(24);

        // Stall three cycles at step 3
        cycle(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        idle(3);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(6);

        // Abort at step 4 of pass 1, then a clean restart
        cycle(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        idle(11);
        cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        idle(3);
        cycle(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        idle(10);

        // start held through RUN and DONE with a changing n_pass
        cycle(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 4'(k), 1'b0, 1'b0);
        idle(20);

        // start together with abort in IDLE
        cycle(1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        idle(2);

        // Reset mid-run at step 5
        cycle(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        idle(5);
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 249) == 0),
                  ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
